// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte-stream
// requesters. The grant is held for a whole frame, so multi-byte frames are never interleaved.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 tx_idle_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic [7:0]           timeout_count
);

  typedef enum logic [1:0] {IDLE, SEND, GUARD} state_t;

  state_t      state, state_nxt;
  logic [2:0]  rr_ptr, rr_ptr_nxt, grant_nxt, pick;
  logic        pick_found;
  logic [15:0] idle_cnt, idle_cnt_nxt;
  logic        last_q, last_nxt;
  logic        tx_start_nxt;
  logic [7:0]  tx_data_nxt, timeout_count_nxt;
  logic        sel_valid, sel_last;
  logic [7:0]  sel_data;
  logic        accept, timed_out;

  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    return (int'(v) == NUM_REQ - 1) ? 3'd0 : v + 3'd1;
  endfunction

  // First requesting index at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        pick       = 3'((int'(rr_ptr) + k) % NUM_REQ);
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == 3'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  assign accept    = (state == SEND) && sel_valid && tx_idle_ready;
  assign timed_out = (state == SEND) && !sel_valid && (idle_cnt == 16'(TIMEOUT - 1));
  assign busy      = (state != IDLE);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state == SEND && grant_id == 3'(i)) req_ready[i] = req_valid[i] & tx_idle_ready;
    end
  end

  // Idle counting only tracks a silent requester; a UART stall with data present clears it.
  always_comb begin
    state_nxt         = state;
    grant_nxt         = grant_id;
    rr_ptr_nxt        = rr_ptr;
    idle_cnt_nxt      = idle_cnt;
    last_nxt          = last_q;
    tx_start_nxt      = 1'b0;
    tx_data_nxt       = tx_data;
    timeout_count_nxt = timeout_count;
    case (state)
      IDLE: begin
        idle_cnt_nxt = '0;
        if (pick_found) begin
          grant_nxt = pick;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          tx_start_nxt = 1'b1;
          tx_data_nxt  = sel_data;
          last_nxt     = sel_last;
          idle_cnt_nxt = '0;
          state_nxt    = GUARD;
        end else if (timed_out) begin
          idle_cnt_nxt = '0;
          rr_ptr_nxt   = wrap_inc(grant_id);
          state_nxt    = IDLE;
          if (timeout_count != 8'hFF) timeout_count_nxt = timeout_count + 8'd1;
        end else if (sel_valid) begin
          idle_cnt_nxt = '0;
        end else begin
          idle_cnt_nxt = idle_cnt + 16'd1;
        end
      end
      GUARD: begin
        idle_cnt_nxt = '0;
        if (last_q) begin
          rr_ptr_nxt = wrap_inc(grant_id);
          state_nxt  = IDLE;
        end else begin
          state_nxt  = SEND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      grant_id      <= '0;
      rr_ptr        <= '0;
      idle_cnt      <= '0;
      last_q        <= 1'b0;
      tx_start      <= 1'b0;
      tx_data       <= '0;
      timeout_count <= '0;
    end else begin
      state         <= state_nxt;
      grant_id      <= grant_nxt;
      rr_ptr        <= rr_ptr_nxt;
      idle_cnt      <= idle_cnt_nxt;
      last_q        <= last_nxt;
      tx_start      <= tx_start_nxt;
      tx_data       <= tx_data_nxt;
      timeout_count <= timeout_count_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requester models feed the DUT, and a scoreboard
// of expected {grant, byte} pairs is checked on every tx_start pulse.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic           tx_idle_ready, tx_start, busy;
  logic [7:0]     tx_data, timeout_count;
  logic [2:0]     grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_idle_ready(tx_idle_ready),
    .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .grant_id(grant_id),
    .timeout_count(timeout_count)
  );

  typedef struct {
    int         grp;
    int         req;
    logic [7:0] data;
    logic       last;
    int         exp_id;
    logic [7:0] exp_data;
  } vec_t;

  vec_t        vecs[$];
  logic [8:0]  rq[N][$];
  logic [10:0] sb[$];
  int          tx_cycles[$];
  int          tests_run = 0;
  int          fails = 0;
  int          cycle = 0;
  int          tx_count = 0;
  logic        prev_tx = 1'b0;
  logic [N-1:0] acc;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = rq[i][0][7:0];
        req_last[i]        = rq[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // Requester models: pop a byte after an edge where it was accepted, abandon all on reset.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!rst) rq[i].delete();
        else if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      end
      refresh();
      #2;
      refresh();
    end
  end

  task automatic check(input string name, input int act, input int expv);
    tests_run++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    logic [10:0] e;
    @(negedge clk);
    check("ready_onehot", int'($countones(req_ready) <= 1), 1);
    check("ready_needs_valid", int'((req_ready & ~(req_valid & {N{tx_idle_ready}})) == '0), 1);
    if (tx_start) begin
      tx_count++;
      tx_cycles.push_back(cycle);
      check("tx_start_not_consecutive", int'(prev_tx), 0);
      if (sb.size() == 0) begin
        check("unexpected_tx_start", 1, 0);
      end else begin
        e = sb.pop_front();
        check("tx_data", int'(tx_data), int'(e[7:0]));
        check("tx_grant", int'(grant_id), int'(e[10:8]));
      end
    end
    prev_tx = tx_start;
  endtask

  task automatic to_load();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_tx(input int bound);
    int c0 = tx_count;
    int n = 0;
    while (tx_count == c0 && n < bound) begin
      tick();
      n++;
    end
    check("wait_tx_in_time", int'(tx_count != c0), 1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((sb.size() > 0 || busy) && n < bound);
    check("frame_done_in_time", int'(sb.size() == 0 && !busy), 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_timeout_count", int'(timeout_count), 0);
    to_load();
    rst = 1'b1;
  endtask

  task automatic add(input int g, input int r, input logic [7:0] d, input logic l,
                     input int ei, input logic [7:0] ed);
    vec_t v;
    v.grp = g; v.req = r; v.data = d; v.last = l; v.exp_id = ei; v.exp_data = ed;
    vecs.push_back(v);
  endtask

  task automatic load_group(input int g);
    foreach (vecs[k]) begin
      if (vecs[k].grp == g) begin
        rq[vecs[k].req].push_back({vecs[k].last, vecs[k].data});
        sb.push_back({3'(vecs[k].exp_id), vecs[k].exp_data});
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0, k, n;
    logic ok;
    rst = 1'b1;
    tx_idle_ready = 1'b1;

    // Rows list inputs in requester order; expected columns list output order.
    add(1, 0, 8'h09, 1'b0, 0, 8'h09);
    add(1, 0, 8'hF6, 1'b1, 0, 8'hF6);
    add(2, 0, 8'h11, 1'b1, 1, 8'h22);
    add(2, 1, 8'h22, 1'b1, 0, 8'h11);
    add(3, 0, 8'hA0, 1'b1, 0, 8'hA0);
    add(3, 1, 8'hA1, 1'b1, 1, 8'hA1);
    add(3, 2, 8'hA2, 1'b1, 2, 8'hA2);
    add(3, 3, 8'hA3, 1'b1, 3, 8'hA3);
    add(4, 1, 8'hB1, 1'b1, 1, 8'hB1);
    add(5, 0, 8'hC0, 1'b1, 2, 8'hC2);
    add(5, 1, 8'hC1, 1'b1, 3, 8'hC3);
    add(5, 2, 8'hC2, 1'b1, 0, 8'hC0);
    add(5, 3, 8'hC3, 1'b1, 1, 8'hC1);

    #1;
    do_reset();

    to_load();
    c0 = cycle;
    tx_cycles.delete();
    load_group(1);
    wait_idle(40);
    check("single_tx_count", tx_cycles.size(), 2);
    if (tx_cycles.size() == 2) begin
      check("single_first_latency", tx_cycles[0], c0 + 2);
      check("single_byte_spacing", tx_cycles[1], c0 + 4);
    end

    to_load();
    load_group(2);
    wait_idle(40);

    do_reset();
    for (int g = 3; g <= 5; g++) begin
      to_load();
      load_group(g);
      wait_idle(80);
    end

    to_load();
    rq[1].push_back({1'b0, 8'hD1});
    rq[1].push_back({1'b1, 8'hD2});
    sb.push_back({3'd1, 8'hD1});
    sb.push_back({3'd1, 8'hD2});
    sb.push_back({3'd0, 8'hD0});
    wait_tx(20);
    to_load();
    rq[0].push_back({1'b1, 8'hD0});
    ok = 1'b1;
    n = 0;
    while ((sb.size() > 0 || busy) && n < 60) begin
      tick();
      n++;
      if (busy && grant_id == 3'd1 && req_ready[0]) ok = 1'b0;
    end
    check("nointerleave_ready0_low", int'(ok), 1);
    check("nointerleave_done", int'(sb.size() == 0 && !busy), 1);

    to_load();
    tx_idle_ready = 1'b0;
    rq[2].push_back({1'b1, 8'hE2});
    sb.push_back({3'd2, 8'hE2});
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (req_ready != '0 || tx_start) ok = 1'b0;
    end
    check("stall_quiet", int'(ok), 1);
    check("stall_no_timeout", int'(timeout_count), 0);
    check("stall_busy", int'(busy), 1);
    check("stall_grant", int'(grant_id), 2);
    to_load();
    k = cycle;
    tx_idle_ready = 1'b1;
    wait_tx(5);
    if (tx_cycles.size() > 0) check("stall_release_cycle", tx_cycles[$], k + 1);
    wait_idle(20);

    to_load();
    rq[3].push_back({1'b0, 8'hF3});
    sb.push_back({3'd3, 8'hF3});
    wait_tx(20);
    to_load();
    rq[0].push_back({1'b1, 8'hF0});
    sb.push_back({3'd0, 8'hF0});
    ok = 1'b1;
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
      if (busy && grant_id != 3'd3) ok = 1'b0;
    end
    check("timeout_release_cycles", n, TMO + 1);
    check("timeout_grant_held", int'(ok), 1);
    check("timeout_count_one", int'(timeout_count), 1);
    tick();
    check("timeout_next_busy", int'(busy), 1);
    check("timeout_next_grant", int'(grant_id), 0);
    wait_idle(20);

    to_load();
    rq[1].push_back({1'b0, 8'h5A});
    rq[1].push_back({1'b1, 8'hA5});
    sb.push_back({3'd1, 8'h5A});
    sb.push_back({3'd1, 8'hA5});
    wait_tx(20);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_tx_start", int'(tx_start), 0);
    check("midrst_tx_data", int'(tx_data), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_grant_id", int'(grant_id), 0);
    check("midrst_timeout_count", int'(timeout_count), 0);
    sb.delete();
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (tx_start) ok = 1'b0;
    end
    check("midrst_no_tx_start", int'(ok), 1);
    to_load();
    rst = 1'b1;
    to_load();
    rq[2].push_back({1'b1, 8'h77});
    rq[3].push_back({1'b1, 8'h88});
    sb.push_back({3'd2, 8'h77});
    sb.push_back({3'd3, 8'h88});
    wait_idle(40);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
